// File: rtl/acc_param_feeder.sv
// acc_param_feeder: streams segment records (dt, steps, parameter words) from a
// first-word-fall-through FIFO into acc_step_gen; preloads, reloads, ends and flushes.
module acc_param_feeder #(
  parameter int N_PARAMS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              host_abort,
  input  logic [31:0]       rd_data,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic              waiting_for_params,
  input  logic              load_next_params,
  input  logic              global_abort,
  input  logic              done,
  input  logic              busy,
  output logic [31:0]       dt_val,
  output logic [31:0]       steps_val,
  output logic [ADDR_W-1:0] param_addr,
  output logic [31:0]       param_data,
  output logic              param_write_lo,
  output logic              param_write_hi,
  output logic              params_load_done,
  output logic              start,
  output logic              abort,
  output logic              prog_active,
  output logic              prog_done,
  output logic              underrun
);

  // One extra counter bit selects lo/hi within a slot.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2 * N_PARAMS - 1);

  typedef enum logic [3:0] {
    IDLE, PL_DT, PL_STEPS, PL_PAR, START, RUN,
    LD_DT, LD_STEPS, LD_PAR, LD_DONE, WAIT_DONE, FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       dt_q, dt_d;
  logic [31:0]       steps_q, steps_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wlo_q, wlo_d;
  logic              whi_q, whi_d;
  logic              pld_q, pld_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              pdone_q, pdone_d;
  logic              underrun_q, underrun_d;
  logic              consuming;
  logic              loading;

  always_comb begin
    consuming = state_q inside {PL_DT, PL_STEPS, PL_PAR, LD_DT, LD_STEPS, LD_PAR, FLUSH};
    loading   = state_q inside {LD_DT, LD_STEPS, LD_PAR};
    rd_en     = consuming && !rd_empty;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dt_d       = dt_q;
    steps_d    = steps_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wlo_d      = 1'b0;
    whi_d      = 1'b0;
    pld_d      = 1'b0;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    pdone_d    = 1'b0;
    underrun_d = underrun_q;

    if (loading && rd_empty) underrun_d = 1'b1;

    // Aborts override everything; a word popped in the abort cycle is discarded.
    if (host_abort && state_q != IDLE) begin
      state_d = FLUSH;
      abort_d = 1'b1;
    end else if (global_abort && state_q != IDLE && state_q != FLUSH) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run && waiting_for_params) begin
            underrun_d = 1'b0;
            state_d    = PL_DT;
          end
        end
        PL_DT, LD_DT: begin
          if (rd_en) begin
            dt_d  = rd_data;
            cnt_d = '0;
            if (rd_data == 32'd0) begin
              if (state_q == PL_DT) begin
                pdone_d = 1'b1;
                state_d = IDLE;
              end else begin
                pld_d   = 1'b1;
                state_d = WAIT_DONE;
              end
            end else if (state_q == PL_DT) begin
              state_d = PL_STEPS;
            end else begin
              state_d = LD_STEPS;
            end
          end
        end
        PL_STEPS, LD_STEPS: begin
          if (rd_en) begin
            steps_d = rd_data;
            if (state_q == PL_STEPS) state_d = PL_PAR;
            else                     state_d = LD_PAR;
          end
        end
        PL_PAR, LD_PAR: begin
          if (rd_en) begin
            addr_d = cnt_q[CNT_W-1:1];
            data_d = rd_data;
            wlo_d  = ~cnt_q[0];
            whi_d  = cnt_q[0];
            if (cnt_q == LAST_WORD) begin
              cnt_d = '0;
              if (state_q == PL_PAR) state_d = START;
              else                   state_d = LD_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        START: begin
          start_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (load_next_params) state_d = LD_DT;
        end
        LD_DONE: begin
          pld_d   = 1'b1;
          state_d = RUN;
        end
        WAIT_DONE: begin
          if (done) begin
            pdone_d = 1'b1;
            state_d = IDLE;
          end
        end
        FLUSH: begin
          if (rd_empty && !busy) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dt_q       <= '0;
      steps_q    <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wlo_q      <= 1'b0;
      whi_q      <= 1'b0;
      pld_q      <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      pdone_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dt_q       <= dt_d;
      steps_q    <= steps_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wlo_q      <= wlo_d;
      whi_q      <= whi_d;
      pld_q      <= pld_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      pdone_q    <= pdone_d;
      underrun_q <= underrun_d;
    end
  end

  assign dt_val           = dt_q;
  assign steps_val        = steps_q;
  assign param_addr       = addr_q;
  assign param_data       = data_q;
  assign param_write_lo   = wlo_q;
  assign param_write_hi   = whi_q;
  assign params_load_done = pld_q;
  assign start            = start_q;
  assign abort            = abort_q;
  assign prog_done        = pdone_q;
  assign underrun         = underrun_q;
  assign prog_active      = (state_q != IDLE);

endmodule
